// File: rtl/cpu_types_pkg.sv
// Shared types for the operand-forwarding slice: FSM states, forward-source
// selects and the saturating statistics increment.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    HOLD
  } fwd_state_e;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_MEM,
    FWD_WB,
    FWD_ZERO
  } fwd_sel_e;

  localparam int unsigned STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand forward-source select and load-use hit detection.
module fwd_src_sel
  import cpu_types_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic              mem_wen,
  input  logic [REG_AW-1:0] mem_wsel,
  input  logic              mem_load,
  input  logic              wb_wen,
  input  logic [REG_AW-1:0] wb_wsel,
  output fwd_sel_e          sel,
  output logic              load_hit
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = mem_wen && (mem_wsel == rs);
    wb_hit  = wb_wen && (wb_wsel == rs);
    // A load in EX/MEM has no data yet; fall through to older stages.
    if (rs == '0) begin
      sel = FWD_ZERO;
    end else if (mem_hit && !mem_load) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    load_hit = (rs != '0) && mem_hit && mem_load;
  end

endmodule

// File: rtl/fwd_operand_unit.sv
// Operand forwarding unit with load-use stall FSM and output skid register.
// Optional statistics counters are enabled by defining FWD_STATS_EN.
module fwd_operand_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            ex_valid,
  output logic                            ex_ready,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]  ex_rs,
  input  logic [NUM_SRC-1:0][WIDTH-1:0]   ex_rdat,
  input  logic                            mem_wen,
  input  logic [REG_AW-1:0]               mem_wsel,
  input  logic                            mem_load,
  input  logic [WIDTH-1:0]                mem_dat,
  input  logic                            wb_wen,
  input  logic [REG_AW-1:0]               wb_wsel,
  input  logic [WIDTH-1:0]                wb_dat,
  output logic                            op_valid,
  input  logic                            op_ready,
  output logic [NUM_SRC-1:0][WIDTH-1:0]   op_dat,
  output logic                            stall
`ifdef FWD_STATS_EN
  ,
  output logic [STAT_W-1:0]               stat_stall,
  output logic [STAT_W-1:0]               stat_fwd_mem,
  output logic [STAT_W-1:0]               stat_fwd_wb
`endif
);

  fwd_sel_e                      sel [NUM_SRC];
  logic [NUM_SRC-1:0]            load_hit;
  logic [NUM_SRC-1:0][WIDTH-1:0] sel_dat;

  fwd_state_e                    state_q, state_d;
  logic                          op_valid_q, op_valid_d;
  logic [NUM_SRC-1:0][WIDTH-1:0] op_dat_q, op_dat_d;

  logic hazard;
  logic capture;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_sel #(
      .REG_AW (REG_AW)
    ) u_sel (
      .rs       (ex_rs[g]),
      .mem_wen  (mem_wen),
      .mem_wsel (mem_wsel),
      .mem_load (mem_load),
      .wb_wen   (wb_wen),
      .wb_wsel  (wb_wsel),
      .sel      (sel[g]),
      .load_hit (load_hit[g])
    );
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      case (sel[i])
        FWD_MEM:  sel_dat[i] = mem_dat;
        FWD_WB:   sel_dat[i] = wb_dat;
        FWD_ZERO: sel_dat[i] = '0;
        default:  sel_dat[i] = ex_rdat[i];
      endcase
    end
  end

  always_comb begin
    hazard   = ex_valid && (|load_hit);
    stall    = (state_q == RUN) && hazard;
    ex_ready = !stall && (!op_valid_q || op_ready);
    capture  = ex_valid && ex_ready;
    op_valid = op_valid_q;
    op_dat   = op_dat_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (hazard) begin
          state_d = LDSTALL;
        end else if (op_valid_q && !op_ready && ex_valid) begin
          state_d = HOLD;
        end
      end
      // One bubble suffices: the load result is in MEM/WB next cycle.
      LDSTALL: state_d = RUN;
      HOLD:    if (op_ready) state_d = RUN;
      default: state_d = RUN;
    endcase

    op_valid_d = capture ? 1'b1 : (op_ready ? 1'b0 : op_valid_q);
    op_dat_d   = capture ? sel_dat : op_dat_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      op_valid_q <= 1'b0;
      op_dat_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_valid_q <= op_valid_d;
      op_dat_q   <= op_dat_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [STAT_W-1:0] stat_stall_q, stat_stall_d;
  logic [STAT_W-1:0] stat_mem_q, stat_mem_d;
  logic [STAT_W-1:0] stat_wb_q, stat_wb_d;
  logic              any_mem, any_wb;

  always_comb begin
    any_mem = 1'b0;
    any_wb  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (sel[i] == FWD_MEM) any_mem = 1'b1;
      if (sel[i] == FWD_WB)  any_wb  = 1'b1;
    end
    stat_stall_d = stall ? sat_inc(stat_stall_q) : stat_stall_q;
    stat_mem_d   = (capture && any_mem) ? sat_inc(stat_mem_q) : stat_mem_q;
    stat_wb_d    = (capture && any_wb) ? sat_inc(stat_wb_q) : stat_wb_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_stall_q <= '0;
      stat_mem_q   <= '0;
      stat_wb_q    <= '0;
    end else begin
      stat_stall_q <= stat_stall_d;
      stat_mem_q   <= stat_mem_d;
      stat_wb_q    <= stat_wb_d;
    end
  end

  always_comb begin
    stat_stall   = stat_stall_q;
    stat_fwd_mem = stat_mem_q;
    stat_fwd_wb  = stat_wb_q;
  end
`endif

endmodule

// File: tb/tb_fwd_operand_unit.sv
// Directed bench for fwd_operand_unit with a behavioural reference model
// checked every cycle plus hand-computed literal expectations.
module tb_fwd_operand_unit;

  localparam int W = 32;
  localparam int N = 2;
  localparam int A = 5;

  logic                CLK = 1'b0;
  logic                nRST;
  logic                ex_valid;
  logic                ex_ready;
  logic [N-1:0][A-1:0] ex_rs;
  logic [N-1:0][W-1:0] ex_rdat;
  logic                mem_wen;
  logic [A-1:0]        mem_wsel;
  logic                mem_load;
  logic [W-1:0]        mem_dat;
  logic                wb_wen;
  logic [A-1:0]        wb_wsel;
  logic [W-1:0]        wb_dat;
  logic                op_valid;
  logic                op_ready;
  logic [N-1:0][W-1:0] op_dat;
  logic                stall;
`ifdef FWD_STATS_EN
  logic [15:0] stat_stall, stat_fwd_mem, stat_fwd_wb;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fwd_operand_unit #(
    .WIDTH   (W),
    .NUM_SRC (N),
    .REG_AW  (A)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .ex_valid (ex_valid),
    .ex_ready (ex_ready),
    .ex_rs    (ex_rs),
    .ex_rdat  (ex_rdat),
    .mem_wen  (mem_wen),
    .mem_wsel (mem_wsel),
    .mem_load (mem_load),
    .mem_dat  (mem_dat),
    .wb_wen   (wb_wen),
    .wb_wsel  (wb_wsel),
    .wb_dat   (wb_dat),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_dat   (op_dat),
    .stall    (stall)
`ifdef FWD_STATS_EN
    ,
    .stat_stall   (stat_stall),
    .stat_fwd_mem (stat_fwd_mem),
    .stat_fwd_wb  (stat_fwd_wb)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Source of operand i: 0 = register file, 1 = EX/MEM, 2 = MEM/WB, 3 = zero.
  function automatic int src_of(int i);
    if (ex_rs[i] == 0) return 3;
    if (mem_wen && !mem_load && mem_wsel == ex_rs[i]) return 1;
    if (wb_wen && wb_wsel == ex_rs[i]) return 2;
    return 0;
  endfunction

  function automatic logic [W-1:0] opnd_of(int i);
    case (src_of(i))
      1:       return mem_dat;
      2:       return wb_dat;
      3:       return '0;
      default: return ex_rdat[i];
    endcase
  endfunction

  function automatic bit any_src(int k);
    for (int i = 0; i < N; i++) if (src_of(i) == k) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit load_use();
    if (!ex_valid || !mem_wen || !mem_load) return 1'b0;
    for (int i = 0; i < N; i++) if (ex_rs[i] != 0 && mem_wsel == ex_rs[i]) return 1'b1;
    return 1'b0;
  endfunction

  bit                  m_valid;
  logic [N-1:0][W-1:0] m_dat;
  bit                  m_bubble_spent;  // stall bubble was issued last cycle
  bit                  m_held;          // consumer backpressure episode ongoing
  logic [15:0]         m_st, m_fm, m_fw;

  function automatic bit exp_stall();
    return !m_bubble_spent && !m_held && load_use();
  endfunction

  function automatic bit exp_ready();
    return !exp_stall() && (!m_valid || op_ready);
  endfunction

  function automatic bit exp_cap();
    return ex_valid && exp_ready();
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_valid        <= 1'b0;
      m_dat          <= '0;
      m_bubble_spent <= 1'b0;
      m_held         <= 1'b0;
      m_st           <= '0;
      m_fm           <= '0;
      m_fw           <= '0;
    end else begin
      if (exp_stall() && m_st != 16'hFFFF) m_st <= m_st + 16'd1;
      if (exp_cap() && any_src(1) && m_fm != 16'hFFFF) m_fm <= m_fm + 16'd1;
      if (exp_cap() && any_src(2) && m_fw != 16'hFFFF) m_fw <= m_fw + 16'd1;
      if (exp_cap()) for (int i = 0; i < N; i++) m_dat[i] <= opnd_of(i);
      m_valid <= exp_cap() ? 1'b1 : (op_ready ? 1'b0 : m_valid);
      if (!m_bubble_spent && !m_held) begin
        m_bubble_spent <= load_use();
        m_held         <= !load_use() && m_valid && !op_ready && ex_valid;
      end else if (m_bubble_spent) begin
        m_bubble_spent <= 1'b0;
      end else if (op_ready) begin
        m_held <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Compare process: just before each rising edge, inputs are settled.
  always @(negedge CLK) begin
    #4;
    chk("model.stall", stall, exp_stall());
    chk("model.ex_ready", ex_ready, exp_ready());
    chk("model.op_valid", op_valid, m_valid);
    if (m_valid) chk("model.op_dat", op_dat, m_dat);
`ifdef FWD_STATS_EN
    chk("model.stat_stall", stat_stall, m_st);
    chk("model.stat_fwd_mem", stat_fwd_mem, m_fm);
    chk("model.stat_fwd_wb", stat_fwd_wb, m_fw);
`endif
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    nRST = 1'b0; ex_valid = 1'b0; op_ready = 1'b1;
    ex_rs = '0; ex_rdat = '0;
    mem_wen = 1'b0; mem_wsel = '0; mem_load = 1'b0; mem_dat = '0;
    wb_wen = 1'b0; wb_wsel = '0; wb_dat = '0;
    repeat (2) tick();
    chk("rst.op_valid", op_valid, 0);
    chk("rst.op_dat", op_dat, 0);
    chk("rst.stall", stall, 0);
    chk("rst.ex_ready", ex_ready, 1);
    nRST = 1'b1;
    tick();

    // EX/MEM forward on operand 0
    ex_valid = 1'b1;
    ex_rs[0] = 5'd8; ex_rdat[0] = 32'hDEAD;
    ex_rs[1] = 5'd3; ex_rdat[1] = 32'h33;
    mem_wen = 1'b1; mem_wsel = 5'd8; mem_dat = 32'h11;
    tick();
    chk("memfwd.op_valid", op_valid, 1);
    chk("memfwd.op0", op_dat[0], 32'h11);
    chk("memfwd.op1", op_dat[1], 32'h33);

    // EX/MEM beats MEM/WB for the same register
    ex_rs[0] = 5'd2; ex_rdat[0] = 32'h22;
    ex_rs[1] = 5'd9; ex_rdat[1] = 32'h99;
    mem_wsel = 5'd9; mem_dat = 32'hAA;
    wb_wen = 1'b1; wb_wsel = 5'd9; wb_dat = 32'hBB;
    tick();
    chk("prio.op1", op_dat[1], 32'hAA);
    chk("prio.op0", op_dat[0], 32'h22);

    // MEM/WB-only forward
    mem_wen = 1'b0; wb_wsel = 5'd2; wb_dat = 32'hCC;
    tick();
    chk("wbfwd.op0", op_dat[0], 32'hCC);
    chk("wbfwd.op1", op_dat[1], 32'h99);

    // Load-use: one stall cycle, then the load data arrives via MEM/WB
    wb_wen = 1'b0;
    mem_wen = 1'b1; mem_load = 1'b1; mem_wsel = 5'd4; mem_dat = 32'hBAD;
    ex_rs[0] = 5'd4; ex_rdat[0] = 32'h44;
    ex_rs[1] = 5'd0; ex_rdat[1] = 32'h1234;
    #1;
    chk("ldu.stall", stall, 1);
    chk("ldu.ex_ready", ex_ready, 0);
    tick();
    chk("ldu.bubble_valid", op_valid, 0);
    mem_wen = 1'b0; mem_load = 1'b0;
    wb_wen = 1'b1; wb_wsel = 5'd4; wb_dat = 32'h55;
    #1;
    chk("ldu.stall_clear", stall, 0);
    tick();
    chk("ldu.op0", op_dat[0], 32'h55);
    chk("ldu.op1_zero", op_dat[1], 32'h0);

    // Hazard persisting into LDSTALL does not re-stall
    wb_wen = 1'b0;
    mem_wen = 1'b1; mem_load = 1'b1; mem_wsel = 5'd6; mem_dat = 32'h0;
    ex_rs[0] = 5'd6; ex_rdat[0] = 32'h66;
    ex_rs[1] = 5'd7; ex_rdat[1] = 32'h70;
    #1;
    chk("persist.stall1", stall, 1);
    tick();
    #1;
    chk("persist.stall2", stall, 0);
    chk("persist.ex_ready", ex_ready, 1);
    tick();
    chk("persist.op0", op_dat[0], 32'h66);

    // Register 0 never forwarded
    mem_load = 1'b0; mem_wen = 1'b1; mem_wsel = 5'd0; mem_dat = 32'hEE;
    wb_wen = 1'b1; wb_wsel = 5'd0; wb_dat = 32'hFF;
    ex_rs[0] = 5'd0; ex_rdat[0] = 32'h77;
    ex_rs[1] = 5'd5; ex_rdat[1] = 32'h50;
    tick();
    chk("r0.op0", op_dat[0], 32'h0);
    chk("r0.op1", op_dat[1], 32'h50);

    // Consumer backpressure for three cycles
    mem_wen = 1'b0; wb_wen = 1'b0; op_ready = 1'b0;
    ex_rs[0] = 5'd1; ex_rdat[0] = 32'h101;
    ex_rs[1] = 5'd2; ex_rdat[1] = 32'h202;
    #1;
    chk("bp.ex_ready0", ex_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp.ex_ready", ex_ready, 0);
      chk("bp.op0_hold", op_dat[0], 32'h0);
      chk("bp.op1_hold", op_dat[1], 32'h50);
    end
    op_ready = 1'b1;
    #1;
    chk("bp.release_ready", ex_ready, 1);
    tick();
    chk("bp.op0_new", op_dat[0], 32'h101);
    chk("bp.op1_new", op_dat[1], 32'h202);
    chk("bp.op_valid", op_valid, 1);

    // Reset during LDSTALL with a held operand
    op_ready = 1'b0;
    mem_wen = 1'b1; mem_load = 1'b1; mem_wsel = 5'd3;
    ex_rs[0] = 5'd3; ex_rdat[0] = 32'h30;
    tick();
    chk("rstmid.valid_before", op_valid, 1);
    nRST = 1'b0; ex_valid = 1'b0;
    #1;
    chk("rstmid.op_valid", op_valid, 0);
    chk("rstmid.stall", stall, 0);
    chk("rstmid.op_dat", op_dat, 0);
`ifdef FWD_STATS_EN
    chk("rstmid.stat_stall", stat_stall, 0);
    chk("rstmid.stat_fwd_mem", stat_fwd_mem, 0);
    chk("rstmid.stat_fwd_wb", stat_fwd_wb, 0);
`endif
    tick();
    nRST = 1'b1; ex_valid = 1'b1; op_ready = 1'b1;
    #1;
    chk("post.stall_new", stall, 1);
    tick();
    mem_wen = 1'b0; mem_load = 1'b0;
    wb_wen = 1'b1; wb_wsel = 5'd3; wb_dat = 32'h333;
    tick();
    chk("post.op0", op_dat[0], 32'h333);
    ex_valid = 1'b0;
    tick();
    chk("post.drain", op_valid, 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
